// File: rtl/zap_wb_master_arb.sv
// N-master Wishbone arbiter/mux. The masters present next-cycle requests; the
// arbiter registers the owner's request onto one bus. Fixed priority by default; define ZAP_WB_ARB_RR_EN for round-robin.
module zap_wb_master_arb #(
  parameter int NUM_MASTERS = 3,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  localparam int IDX_W      = ($clog2(NUM_MASTERS) > 1) ? $clog2(NUM_MASTERS) : 1,
  localparam int SEL_W      = DATA_W / 8
) (
  input  logic                          i_clk,
  input  logic                          i_reset_n,
  input  logic [NUM_MASTERS-1:0]        i_m_cyc_nxt,
  input  logic [NUM_MASTERS-1:0]        i_m_stb_nxt,
  input  logic [NUM_MASTERS-1:0]        i_m_wen_nxt,
  input  logic [NUM_MASTERS*SEL_W-1:0]  i_m_sel_nxt,
  input  logic [NUM_MASTERS*DATA_W-1:0] i_m_dat_nxt,
  input  logic [NUM_MASTERS*ADDR_W-1:0] i_m_adr_nxt,
  input  logic [NUM_MASTERS*3-1:0]      i_m_cti_nxt,
  output logic [NUM_MASTERS-1:0]        o_m_ack,
  output logic [NUM_MASTERS-1:0]        o_m_err,
  output logic                          o_wb_cyc,
  output logic                          o_wb_stb,
  output logic                          o_wb_wen,
  output logic [SEL_W-1:0]              o_wb_sel,
  output logic [DATA_W-1:0]             o_wb_dat,
  output logic [ADDR_W-1:0]             o_wb_adr,
  output logic [2:0]                    o_wb_cti,
  output logic                          o_wb_cyc_nxt,
  output logic                          o_wb_stb_nxt,
  output logic                          o_wb_wen_nxt,
  output logic [SEL_W-1:0]              o_wb_sel_nxt,
  output logic [DATA_W-1:0]             o_wb_dat_nxt,
  output logic [ADDR_W-1:0]             o_wb_adr_nxt,
  output logic [2:0]                    o_wb_cti_nxt,
  input  logic                          i_wb_ack,
  input  logic                          i_wb_err,
  input  logic [DATA_W-1:0]             i_wb_dat,
  output logic [IDX_W-1:0]              o_owner,
  output logic                          o_busy
);

  logic [IDX_W-1:0]  owner_q, owner_d, winner;
  logic              cyc_q, stb_q, wen_q;
  logic [SEL_W-1:0]  sel_q;
  logic [DATA_W-1:0] dat_q;
  logic [ADDR_W-1:0] adr_q;
  logic [2:0]        cti_q;
  logic              own_cyc, arb_ok, any_req;

  // Read data is fanned out to the masters outside this block.
  logic unused_rdata;
  assign unused_rdata = ^i_wb_dat;

  always_comb begin
    own_cyc = 1'b0;
    for (int k = 0; k < NUM_MASTERS; k++)
      if (owner_q == IDX_W'(k)) own_cyc = i_m_cyc_nxt[k];
  end

  // Owner keeps the bus while it holds CYC across beats.
  assign arb_ok  = (!stb_q || i_wb_ack || i_wb_err) && !(cyc_q && own_cyc);
  assign any_req = |i_m_cyc_nxt;

`ifdef ZAP_WB_ARB_RR_EN
  logic [IDX_W-1:0] hi_win, lo_win;
  logic             hi_found;

  // Lowest requester above the owner, else lowest requester overall (wrap).
  always_comb begin
    hi_win   = '0;
    lo_win   = '0;
    hi_found = 1'b0;
    for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
      if (i_m_cyc_nxt[k]) begin
        lo_win = IDX_W'(k);
        if (IDX_W'(k) > owner_q) begin
          hi_win   = IDX_W'(k);
          hi_found = 1'b1;
        end
      end
    end
    winner = hi_found ? hi_win : lo_win;
  end
`else
  always_comb begin
    winner = owner_q;
    for (int k = 0; k < NUM_MASTERS; k++)
      if (i_m_cyc_nxt[k]) winner = IDX_W'(k);
  end
`endif

  assign owner_d = (arb_ok && any_req) ? winner : owner_q;

  always_comb begin
    o_wb_cyc_nxt = 1'b0;
    o_wb_stb_nxt = 1'b0;
    o_wb_wen_nxt = 1'b0;
    o_wb_sel_nxt = '0;
    o_wb_dat_nxt = '0;
    o_wb_adr_nxt = '0;
    o_wb_cti_nxt = 3'b000;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (owner_d == IDX_W'(k)) begin
        o_wb_cyc_nxt = i_m_cyc_nxt[k];
        o_wb_stb_nxt = i_m_stb_nxt[k];
        o_wb_wen_nxt = i_m_wen_nxt[k];
        o_wb_sel_nxt = i_m_sel_nxt[k*SEL_W +: SEL_W];
        o_wb_dat_nxt = i_m_dat_nxt[k*DATA_W +: DATA_W];
        o_wb_adr_nxt = i_m_adr_nxt[k*ADDR_W +: ADDR_W];
        o_wb_cti_nxt = i_m_cti_nxt[k*3 +: 3];
      end
    end
  end

  always_comb begin
    o_m_ack = '0;
    o_m_err = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (owner_q == IDX_W'(k)) begin
        o_m_ack[k] = i_wb_ack;
        o_m_err[k] = i_wb_err;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      owner_q <= '0;
      cyc_q   <= 1'b0;
      stb_q   <= 1'b0;
      wen_q   <= 1'b0;
      sel_q   <= '0;
      dat_q   <= '0;
      adr_q   <= '0;
      cti_q   <= 3'b000;
    end else begin
      owner_q <= owner_d;
      cyc_q   <= o_wb_cyc_nxt;
      stb_q   <= o_wb_stb_nxt;
      wen_q   <= o_wb_wen_nxt;
      sel_q   <= o_wb_sel_nxt;
      dat_q   <= o_wb_dat_nxt;
      adr_q   <= o_wb_adr_nxt;
      cti_q   <= o_wb_cti_nxt;
    end
  end

  assign o_wb_cyc = cyc_q;
  assign o_wb_stb = stb_q;
  assign o_wb_wen = wen_q;
  assign o_wb_sel = sel_q;
  assign o_wb_dat = dat_q;
  assign o_wb_adr = adr_q;
  assign o_wb_cti = cti_q;
  assign o_owner  = owner_q;
  assign o_busy   = cyc_q;

endmodule

// File: tb/tb_zap_wb_master_arb.sv
// Self-checking bench for zap_wb_master_arb: directed vector table, handover
// and rotation sequences, then random traffic against a reference model.
module tb_zap_wb_master_arb;
`ifdef ZAP_WB_ARB_RR_EN
  localparam int NM = 4;
  localparam bit RR = 1'b1;
`else
  localparam int NM = 3;
  localparam bit RR = 1'b0;
`endif
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int IW = ($clog2(NM) > 1) ? $clog2(NM) : 1;

  logic i_clk, i_reset_n;
  logic [NM-1:0] m_cyc, m_stb, m_wen;
  logic [SW-1:0] sel_a [NM];
  logic [DW-1:0] dat_a [NM];
  logic [AW-1:0] adr_a [NM];
  logic [2:0]    cti_a [NM];
  logic [NM*SW-1:0] m_sel;
  logic [NM*DW-1:0] m_dat;
  logic [NM*AW-1:0] m_adr;
  logic [NM*3-1:0]  m_cti;
  logic [NM-1:0] o_m_ack, o_m_err;
  logic o_wb_cyc, o_wb_stb, o_wb_wen, o_wb_cyc_nxt, o_wb_stb_nxt, o_wb_wen_nxt;
  logic [SW-1:0] o_wb_sel, o_wb_sel_nxt;
  logic [DW-1:0] o_wb_dat, o_wb_dat_nxt, i_wb_dat;
  logic [AW-1:0] o_wb_adr, o_wb_adr_nxt;
  logic [2:0]    o_wb_cti, o_wb_cti_nxt;
  logic i_wb_ack, i_wb_err;
  logic [IW-1:0] o_owner;
  logic o_busy;

  always_comb begin
    m_sel = '0; m_dat = '0; m_adr = '0; m_cti = '0;
    for (int k = 0; k < NM; k++) begin
      m_sel[k*SW +: SW] = sel_a[k];
      m_dat[k*DW +: DW] = dat_a[k];
      m_adr[k*AW +: AW] = adr_a[k];
      m_cti[k*3 +: 3]   = cti_a[k];
    end
  end

  zap_wb_master_arb #(.NUM_MASTERS(NM), .ADDR_W(AW), .DATA_W(DW)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n),
    .i_m_cyc_nxt(m_cyc), .i_m_stb_nxt(m_stb), .i_m_wen_nxt(m_wen),
    .i_m_sel_nxt(m_sel), .i_m_dat_nxt(m_dat), .i_m_adr_nxt(m_adr), .i_m_cti_nxt(m_cti),
    .o_m_ack(o_m_ack), .o_m_err(o_m_err),
    .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_wen(o_wb_wen), .o_wb_sel(o_wb_sel),
    .o_wb_dat(o_wb_dat), .o_wb_adr(o_wb_adr), .o_wb_cti(o_wb_cti),
    .o_wb_cyc_nxt(o_wb_cyc_nxt), .o_wb_stb_nxt(o_wb_stb_nxt), .o_wb_wen_nxt(o_wb_wen_nxt),
    .o_wb_sel_nxt(o_wb_sel_nxt), .o_wb_dat_nxt(o_wb_dat_nxt), .o_wb_adr_nxt(o_wb_adr_nxt),
    .o_wb_cti_nxt(o_wb_cti_nxt),
    .i_wb_ack(i_wb_ack), .i_wb_err(i_wb_err), .i_wb_dat(i_wb_dat),
    .o_owner(o_owner), .o_busy(o_busy)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  int checks = 0;
  int errors = 0;

  // Reference model: owner and the registered bus, updated from the rules directly.
  int            mo_owner;
  logic          mo_cyc, mo_stb, mo_wen;
  logic [SW-1:0] mo_sel;
  logic [DW-1:0] mo_dat;
  logic [AW-1:0] mo_adr;
  logic [2:0]    mo_cti;

  // DUT samples from the most recent step, used by directed checks.
  logic [NM-1:0] s_ack, s_err;
  logic          s_cycn, s_cyc;
  logic [AW-1:0] s_adrn, s_adr;
  int            s_own;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    mo_owner = 0; mo_cyc = 0; mo_stb = 0; mo_wen = 0;
    mo_sel = '0; mo_dat = '0; mo_adr = '0; mo_cti = 3'b000;
  endtask

  function automatic int pick_winner(input logic [NM-1:0] req, input int cur);
    int best, bd, d;
    best = cur;
    bd   = NM + 1;
    for (int k = 0; k < NM; k++) begin
      if (req[k]) begin
        if (RR) begin
          d = (k - cur + NM) % NM;
          if (d == 0) d = NM;
          if (d < bd) begin bd = d; best = k; end
        end else begin
          best = k;
        end
      end
    end
    return best;
  endfunction

  // Called at a negedge with master inputs already set; returns at the next negedge.
  task automatic step(input logic ack, input logic err);
    int nxt;
    logic [NM-1:0] eack, eerr;
    i_wb_ack = ack;
    i_wb_err = err;
    #1;
    nxt = mo_owner;
    if ((!mo_stb || ack || err) && !(mo_cyc && m_cyc[mo_owner]) && (m_cyc != '0))
      nxt = pick_winner(m_cyc, mo_owner);
    eack = ack ? (NM'(1) << mo_owner) : '0;
    eerr = err ? (NM'(1) << mo_owner) : '0;
    chk("m_ack", o_m_ack, eack);
    chk("m_err", o_m_err, eerr);
    chk("cyc_nxt", o_wb_cyc_nxt, m_cyc[nxt]);
    chk("adr_nxt", o_wb_adr_nxt, adr_a[nxt]);
    s_ack = o_m_ack; s_err = o_m_err; s_cycn = o_wb_cyc_nxt; s_adrn = o_wb_adr_nxt;
    @(posedge i_clk);
    mo_owner = nxt;
    mo_cyc = m_cyc[nxt]; mo_stb = m_stb[nxt]; mo_wen = m_wen[nxt];
    mo_sel = sel_a[nxt]; mo_dat = dat_a[nxt]; mo_adr = adr_a[nxt]; mo_cti = cti_a[nxt];
    #1;
    chk("owner", o_owner, mo_owner);
    chk("wb_cyc", o_wb_cyc, mo_cyc);
    chk("wb_stb", o_wb_stb, mo_stb);
    chk("wb_wen", o_wb_wen, mo_wen);
    chk("wb_sel", o_wb_sel, mo_sel);
    chk("wb_dat", o_wb_dat, mo_dat);
    chk("wb_adr", o_wb_adr, mo_adr);
    chk("wb_cti", o_wb_cti, mo_cti);
    chk("busy", o_busy, mo_cyc);
    s_own = int'(o_owner); s_cyc = o_wb_cyc; s_adr = o_wb_adr;
    @(negedge i_clk);
  endtask

  task automatic set_fixed_fields();
    for (int k = 0; k < NM; k++) begin
      adr_a[k] = AW'(k * 32'h100);
      dat_a[k] = DW'(32'hA000 + k);
      sel_a[k] = '1;
      cti_a[k] = (k == 0) ? 3'b010 : 3'b000;
    end
    m_wen = '0;
  endtask

  task automatic drive(input logic [NM-1:0] cyc);
    m_cyc = cyc;
    m_stb = cyc;
  endtask

  typedef struct {
    logic [NM-1:0] cyc;
    logic          ack;
    logic          err;
    logic [NM-1:0] eack;
    logic [NM-1:0] eerr;
    logic          ecycn;
    int            eown;
    logic [AW-1:0] eadr;
  } vec_t;

  vec_t tv[15];
  int   cnt[NM];
  logic [NM-1:0] all_m;

  initial begin
    tv[0]  = '{3'b010, 0, 0, 3'b000, 3'b000, 1, 1, 32'h100};
    tv[1]  = '{3'b010, 0, 0, 3'b000, 3'b000, 1, 1, 32'h100};
    tv[2]  = '{3'b010, 0, 0, 3'b000, 3'b000, 1, 1, 32'h100};
    tv[3]  = '{3'b000, 1, 0, 3'b010, 3'b000, 0, 1, 32'h100};
    tv[4]  = '{3'b000, 0, 0, 3'b000, 3'b000, 0, 1, 32'h100};
    tv[5]  = '{3'b010, 0, 0, 3'b000, 3'b000, 1, 1, 32'h100};
    tv[6]  = '{3'b000, 0, 1, 3'b000, 3'b010, 0, 1, 32'h100};
    tv[7]  = '{3'b000, 0, 0, 3'b000, 3'b000, 0, 1, 32'h100};
    tv[8]  = '{3'b001, 0, 0, 3'b000, 3'b000, 1, 0, 32'h000};
    tv[9]  = '{3'b001, 1, 0, 3'b001, 3'b000, 1, 0, 32'h000};
    tv[10] = '{3'b101, 1, 0, 3'b001, 3'b000, 1, 0, 32'h000};
    tv[11] = '{3'b101, 1, 0, 3'b001, 3'b000, 1, 0, 32'h000};
    tv[12] = '{3'b100, 1, 0, 3'b001, 3'b000, 1, 2, 32'h200};
    tv[13] = '{3'b000, 1, 0, 3'b100, 3'b000, 0, 2, 32'h200};
    tv[14] = '{3'b000, 0, 0, 3'b000, 3'b000, 0, 2, 32'h200};

    // Reset with random inputs: registered outputs must be zero.
    i_reset_n = 1'b0;
    m_cyc = NM'($urandom); m_stb = NM'($urandom); m_wen = NM'($urandom);
    for (int k = 0; k < NM; k++) begin
      adr_a[k] = $urandom; dat_a[k] = $urandom; sel_a[k] = SW'($urandom); cti_a[k] = 3'($urandom);
    end
    i_wb_ack = 1'($urandom); i_wb_err = 1'($urandom); i_wb_dat = $urandom;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    chk("rst_owner", o_owner, 0);
    chk("rst_cyc", o_wb_cyc, 0);
    chk("rst_stb", o_wb_stb, 0);
    chk("rst_wen", o_wb_wen, 0);
    chk("rst_sel", o_wb_sel, 0);
    chk("rst_dat", o_wb_dat, 0);
    chk("rst_adr", o_wb_adr, 0);
    chk("rst_cti", o_wb_cti, 0);
    chk("rst_busy", o_busy, 0);
    model_reset();
    set_fixed_fields();
    drive('0);
    i_wb_ack = 1'b0; i_wb_err = 1'b0;
    i_reset_n = 1'b1;

    // Directed vectors: single read with wait states, error beat, locked burst.
    for (int i = 0; i < 15; i++) begin
      drive(tv[i].cyc);
      step(tv[i].ack, tv[i].err);
      chk($sformatf("tv%0d_ack", i), s_ack, tv[i].eack);
      chk($sformatf("tv%0d_err", i), s_err, tv[i].eerr);
      chk($sformatf("tv%0d_cycn", i), s_cycn, tv[i].ecycn);
      chk($sformatf("tv%0d_own", i), s_own, tv[i].eown);
      chk($sformatf("tv%0d_adr", i), s_adr, tv[i].eadr);
    end

    if (!RR) begin
      // Masters 0 and 2 together: 2 first, 0 takes over in 2's ACK cycle.
      drive(NM'(3'b101)); step(0, 0);
      chk("fp_first_own", s_own, 2);
      drive(NM'(3'b101)); step(0, 0);
      chk("fp_hold_own", s_own, 2);
      drive(NM'(3'b001)); step(1, 0);
      chk("fp_ho_ack", s_ack, NM'(3'b100));
      chk("fp_ho_cycn", s_cycn, 1);
      chk("fp_ho_adrn", s_adrn, 0);
      chk("fp_ho_own", s_own, 0);
      chk("fp_ho_cyc", s_cyc, 1);
      drive('0); step(1, 0);
      chk("fp_m0_ack", s_ack, NM'(3'b001));
    end else begin
      // Every master requests single beats; each gets one of every NM ACKs.
      all_m = '1;
      for (int k = 0; k < NM; k++) cnt[k] = 0;
      drive(all_m & ~(NM'(1) << mo_owner)); step(0, 0);
      for (int i = 0; i < 2 * NM; i++) begin
        drive(all_m & ~(NM'(1) << mo_owner));
        step(1, 0);
        for (int k = 0; k < NM; k++) if (s_ack[k]) cnt[k]++;
      end
      for (int k = 0; k < NM; k++) chk($sformatf("rr_cnt%0d", k), cnt[k], 2);
      drive('0); step(1, 0);
    end

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < NM; k++) begin
        m_cyc[k] = ($urandom_range(0, 3) != 0);
        m_stb[k] = m_cyc[k] & ($urandom_range(0, 7) != 0);
        m_wen[k] = 1'($urandom);
        adr_a[k] = $urandom; dat_a[k] = $urandom;
        sel_a[k] = SW'($urandom); cti_a[k] = 3'($urandom);
      end
      i_wb_dat = $urandom;
      step(1'($urandom), ($urandom_range(0, 7) == 0));
    end

    // Reset asserted mid-burst clears the bus immediately.
    set_fixed_fields();
    drive('0); step(1, 0);
    step(0, 0);
    drive(NM'(3'b001)); step(0, 0);
    step(1, 0);
    chk("mb_pre_cyc", o_wb_cyc, 1);
    i_reset_n = 1'b0;
    #1;
    chk("mb_cyc", o_wb_cyc, 0);
    chk("mb_stb", o_wb_stb, 0);
    chk("mb_own", o_owner, 0);
    chk("mb_cti", o_wb_cti, 0);
    @(negedge i_clk);
    model_reset();
    drive('0);
    i_reset_n = 1'b1;
    step(0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
